// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the program counter, reads a synchronous
// instruction memory and presents each word to the decoder over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// BOOT    | first cycle out of reset, memory left idle
// FETCH   | read strobe issued at program_counter
// CAPTURE | memory data lands in the instruction register
// ISSUE   | word offered to decoder; PC steps on acceptance
module instruction_fetch_unit #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic [15:0] imem_addr,
   output logic        imem_read,
   input  logic [15:0] imem_data,
   output logic [11:0] instruction,
   output logic [3:0]  opcode_class,
   output logic        instruction_valid,
   input  logic        instruction_ready,
   input  logic        program_counter_increment,
   input  logic        jump,
   input  logic [15:0] jump_target,
   output logic [15:0] program_counter
);

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      FETCH   = 2'd1,
      CAPTURE = 2'd2,
      ISSUE   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] pc;
   logic [15:0] pc_nxt;
   logic [15:0] instr_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= BOOT;
         pc        <= RESET_VECTOR;
         instr_reg <= 16'h0000;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (state == CAPTURE) begin
            instr_reg <= imem_data;
         end
      end
   end

   always_comb begin
      state_nxt         = state;
      pc_nxt            = pc;
      imem_read         = 1'b0;
      instruction_valid = 1'b0;
      case (state)
         BOOT: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            imem_read = 1'b1;
            state_nxt = CAPTURE;
         end
         CAPTURE: begin
            state_nxt = ISSUE;
         end
         ISSUE: begin
            instruction_valid = 1'b1;
            if (instruction_ready) begin
               state_nxt = FETCH;
               // jump wins over increment; neither means refetch the same word
               if (jump) begin
                  pc_nxt = jump_target;
               end else if (program_counter_increment) begin
                  pc_nxt = pc + 16'd1;
               end
            end
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   assign imem_addr       = pc;
   assign program_counter = pc;
   assign instruction     = instr_reg[11:0];
   assign opcode_class    = instr_reg[15:12];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by
// randomized traffic, compared every cycle against a cycle-countdown reference model.
module tb_instruction_fetch_unit;

   localparam logic [15:0] RV = 16'h0010;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] imem_addr;
   logic        imem_read;
   logic [15:0] imem_data = 16'h0000;
   logic [11:0] instruction;
   logic [3:0]  opcode_class;
   logic        instruction_valid;
   logic        instruction_ready;
   logic        program_counter_increment;
   logic        jump;
   logic [15:0] jump_target;
   logic [15:0] program_counter;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: m_wait counts cycles until the word is on offer
   logic [15:0] m_pc;
   logic [15:0] m_ir;
   int          m_wait;
   int          cyc;
   logic        saw_addr6;

   instruction_fetch_unit #(.RESET_VECTOR(RV)) dut (
      .clock                     (clock),
      .reset                     (reset),
      .imem_addr                 (imem_addr),
      .imem_read                 (imem_read),
      .imem_data                 (imem_data),
      .instruction               (instruction),
      .opcode_class              (opcode_class),
      .instruction_valid         (instruction_valid),
      .instruction_ready         (instruction_ready),
      .program_counter_increment (program_counter_increment),
      .jump                      (jump),
      .jump_target               (jump_target),
      .program_counter           (program_counter)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [31:0] h;
      if (a == 16'h0010) return 16'h1A5C;
      h = {16'h0000, a} * 32'h0000_9E37;
      return h[15:0] ^ 16'hC3A5 ^ {a[7:0], a[15:8]};
   endfunction

   always @(posedge clock) begin
      if (imem_read) begin
         imem_data <= mem_word(imem_addr);
         if (imem_addr == 16'h0006) saw_addr6 <= 1'b1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_update(input logic rst, rdy, inc, jmp, input logic [15:0] tgt);
      if (rst) begin
         m_pc   = RV;
         m_ir   = 16'h0000;
         m_wait = 3;
         cyc    = 0;
      end else begin
         cyc++;
         if (m_wait == 0) begin
            if (rdy) begin
               if (jmp)      m_pc = tgt;
               else if (inc) m_pc = m_pc + 16'd1;
               m_wait = 2;
            end
         end else begin
            if (m_wait == 1) m_ir = mem_word(m_pc);
            m_wait--;
         end
      end
   endtask

   task automatic check_cycle();
      check_val("valid",   {31'd0, instruction_valid}, {31'd0, (m_wait == 0)});
      check_val("read",    {31'd0, imem_read},         {31'd0, (m_wait == 2)});
      check_val("pc",      {16'd0, program_counter},   {16'd0, m_pc});
      check_val("addr",    {16'd0, imem_addr},         {16'd0, m_pc});
      check_val("ir",      {16'd0, opcode_class, instruction}, {16'd0, m_ir});
   endtask

   task automatic step(input logic rst, rdy, inc, jmp, input logic [15:0] tgt);
      reset                     = rst;
      instruction_ready         = rdy;
      program_counter_increment = inc;
      jump                      = jmp;
      jump_target               = tgt;
      @(posedge clock);
      model_update(rst, rdy, inc, jmp, tgt);
      #1;
      check_cycle();
   endtask

   task automatic step_idle();
      step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
   endtask

   task automatic wait_issue();
      int guard = 0;
      while (!instruction_valid && guard < 8) begin
         step_idle();
         guard++;
      end
      check_val("issue_reached", {31'd0, instruction_valid}, 32'd1);
   endtask

   task automatic accept(input logic inc, jmp, input logic [15:0] tgt);
      wait_issue();
      step(1'b0, 1'b1, inc, jmp, tgt);
   endtask

   initial begin
      int k;
      logic [15:0] p;
      saw_addr6 = 1'b0;

      // reset and sequential run from the reset vector
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      check_val("rst_valid", {31'd0, instruction_valid}, 32'd0);
      check_val("rst_read",  {31'd0, imem_read}, 32'd0);
      check_val("rst_pc",    {16'd0, program_counter}, {16'd0, RV});
      check_val("rst_ir",    {16'd0, opcode_class, instruction}, 32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      k = 0;
      for (int i = 0; i < 10; i++) begin
         if (cyc == 3) begin
            check_val("first_valid",  {31'd0, instruction_valid}, 32'd1);
            check_val("first_class",  {28'd0, opcode_class}, 32'h1);
            check_val("first_instr",  {20'd0, instruction}, 32'hA5C);
         end
         if (imem_read) begin
            check_val("seq_fetch_cycle", cyc, 1 + 3 * k);
            check_val("seq_fetch_addr",  {16'd0, imem_addr}, {16'd0, RV + 16'(k)});
            k++;
         end
         step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      end
      check_val("seq_fetch_count", k, 4);

      // jump at PC 5 with increment also set
      accept(1'b1, 1'b1, 16'h0005);
      accept(1'b1, 1'b0, 16'h0000);
      accept(1'b0, 1'b0, 16'h0000);
      accept(1'b1, 1'b1, 16'h0005);
      wait_issue();
      check_val("jump_at_pc5", {16'd0, program_counter}, 32'h0005);
      saw_addr6 = 1'b0;
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0100);
      check_val("jump_read", {31'd0, imem_read}, 32'd1);
      check_val("jump_addr", {16'd0, imem_addr}, 32'h0100);
      wait_issue();
      check_val("no_wrong_path", {31'd0, saw_addr6}, 32'd0);

      // five stall cycles then accept with increment
      p = m_pc;
      for (int i = 0; i < 5; i++) begin
         step_idle();
         check_val("stall_valid", {31'd0, instruction_valid}, 32'd1);
         check_val("stall_pc",    {16'd0, program_counter}, {16'd0, p});
      end
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      check_val("post_stall_addr", {16'd0, imem_addr}, {16'd0, p + 16'd1});

      // wrap at 16'hFFFF, then halt refetch
      accept(1'b1, 1'b1, 16'hFFFF);
      accept(1'b1, 1'b0, 16'h1234);
      check_val("wrap_addr", {16'd0, imem_addr}, 32'h0000);
      check_val("wrap_read", {31'd0, imem_read}, 32'd1);
      accept(1'b0, 1'b0, 16'h4321);
      check_val("halt_addr", {16'd0, imem_addr}, 32'h0000);
      check_val("halt_read", {31'd0, imem_read}, 32'd1);

      // reset while the word is in CAPTURE
      accept(1'b1, 1'b1, 16'h0777);
      step_idle();
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         check_val("midrst_valid", {31'd0, instruction_valid}, 32'd0);
         check_val("midrst_pc",    {16'd0, program_counter}, {16'd0, RV});
         step_idle();
      end
      check_val("midrst_new_word", {16'd0, opcode_class, instruction}, 32'h1A5C);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 199) == 0),
              1'($urandom),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 7) == 0),
              16'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
